// File: rtl/xgmii_lb_channel.sv
// XGMII loopback channel: programmable-delay circular buffer feeding a
// frame-aware pass/idle/abort state machine with saturating statistics.

module xgmii_lb_lane (
  input  logic [1:0] sel,
  input  logic       inj,
  input  logic [7:0] din,
  input  logic       cin,
  output logic [7:0] dout,
  output logic       cout,
  output logic       term
);
  localparam logic [1:0] SEL_ERR  = 2'd1;
  localparam logic [1:0] SEL_PASS = 2'd2;

  always_comb begin
    dout = 8'h07;
    cout = 1'b1;
    if (sel == SEL_ERR || (sel == SEL_PASS && inj)) begin
      dout = 8'hFE;
    end else if (sel == SEL_PASS) begin
      dout = din;
      cout = cin;
    end
  end

  assign term = cin && (din == 8'hFD);
endmodule

module xgmii_lb_channel #(
  parameter  int LANES     = 8,
  parameter  int MAX_DELAY = 16,
  parameter  int CNT_W     = 32,
  localparam int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic               clk_156m25,
  input  logic               reset_156m25_n,
  input  logic [LANES*8-1:0] xgmii_txd,
  input  logic [LANES-1:0]   xgmii_txc,
  input  logic               cfg_mode,
  input  logic [DW-1:0]      cfg_delay,
  input  logic               err_inject,
  output logic [LANES*8-1:0] xgmii_rxd,
  output logic [LANES-1:0]   xgmii_rxc,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               busy
);
  localparam int            DEPTH    = MAX_DELAY + 1;
  localparam logic [DW-1:0] DMAX     = DW'(MAX_DELAY);
  localparam logic [1:0]    SEL_IDLE = 2'd0;
  localparam logic [1:0]    SEL_ERR  = 2'd1;
  localparam logic [1:0]    SEL_PASS = 2'd2;

  typedef struct packed {
    logic [LANES-1:0][7:0] d;
    logic [LANES-1:0]      c;
  } xword_t;

  typedef enum logic [2:0] {FILL, HUNT, PASS, ABORT, BLOCK} state_t;

  xword_t                mem [DEPTH];
  xword_t                wr_word, dword;
  logic [DW-1:0]         wptr, rptr, lat_dly, dly, cfg_clamp, fill_cnt;
  logic                  armed, chg, in_frame, in_frame_nx, pending, pending_nx;
  logic                  a2f, a2f_nx, inj, is_start, term_any, err_inc, frm_inc;
  state_t                state, state_nx;
  logic [1:0]            sel;
  logic [LANES-1:0][7:0] lane_d;
  logic [LANES-1:0]      lane_c, lane_t;

  assign wr_word   = {xgmii_txd, xgmii_txc};
  assign cfg_clamp = (cfg_delay > DMAX) ? DMAX : cfg_delay;
  // Until the first edge after reset the live (clamped) delay is used, which
  // is how the delay gets sampled at reset release.
  assign dly       = armed ? lat_dly : cfg_clamp;
  assign chg       = armed && (cfg_clamp != lat_dly);
  assign rptr      = (wptr >= dly) ? wptr - dly : wptr + DW'(DEPTH) - dly;
  // Zero delay reads the slot being written this cycle, so bypass the RAM.
  assign dword     = (dly == '0) ? wr_word : mem[rptr];
  assign is_start  = dword.c[0] && (dword.d[0] == 8'hFB);
  assign term_any  = |lane_t;
  assign busy      = (state != PASS);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    xgmii_lb_lane u_lane (
      .sel  (sel),
      .inj  ((g == 0) ? inj : 1'b0),
      .din  (dword.d[g]),
      .cin  (dword.c[g]),
      .dout (lane_d[g]),
      .cout (lane_c[g]),
      .term (lane_t[g])
    );
  end

  always_comb begin
    state_nx    = state;
    sel         = SEL_IDLE;
    inj         = 1'b0;
    in_frame_nx = in_frame;
    a2f_nx      = a2f;
    case (state)
      FILL: begin
        if (chg)                  state_nx = FILL;
        else if (fill_cnt == dly) state_nx = cfg_mode ? BLOCK : HUNT;
      end
      HUNT: begin
        if (chg)           state_nx = FILL;
        else if (cfg_mode) state_nx = BLOCK;
        else if (is_start) begin
          sel         = SEL_PASS;
          state_nx    = PASS;
          in_frame_nx = 1'b1;
        end
      end
      PASS: begin
        if (chg || cfg_mode) begin
          // Mid-frame exit: the current word still goes out untouched, the
          // abort word follows; any pending inject is dropped.
          if (in_frame) begin
            sel      = SEL_PASS;
            state_nx = ABORT;
            a2f_nx   = chg;
          end else begin
            state_nx = chg ? FILL : BLOCK;
          end
        end else begin
          sel = SEL_PASS;
          inj = pending && in_frame && !dword.c[0];
          if (term_any)      in_frame_nx = 1'b0;
          else if (is_start) in_frame_nx = 1'b1;
        end
      end
      ABORT: begin
        sel      = SEL_ERR;
        state_nx = (chg || a2f) ? FILL : BLOCK;
      end
      BLOCK: begin
        if (chg)           state_nx = FILL;
        else if (!cfg_mode) state_nx = HUNT;
      end
      default: state_nx = FILL;
    endcase
    if (state_nx != PASS) in_frame_nx = 1'b0;
    if (state_nx != ABORT) a2f_nx = 1'b0;
  end

  always_comb begin
    pending_nx = pending;
    if (inj || (state == PASS && state_nx != PASS)) pending_nx = 1'b0;
    else if (err_inject)                            pending_nx = 1'b1;
  end

  assign err_inc = (state == ABORT) || inj;
  assign frm_inc = lane_c[0] && (lane_d[0] == 8'hFB);

  always_ff @(posedge clk_156m25) begin
    mem[wptr] <= wr_word;
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state     <= FILL;
      armed     <= 1'b0;
      lat_dly   <= '0;
      wptr      <= '0;
      fill_cnt  <= '0;
      in_frame  <= 1'b0;
      pending   <= 1'b0;
      a2f       <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      xgmii_rxd <= {LANES{8'h07}};
      xgmii_rxc <= '1;
    end else begin
      state    <= state_nx;
      armed    <= 1'b1;
      if (!armed || chg) lat_dly <= cfg_clamp;
      wptr     <= (wptr == DMAX) ? '0 : wptr + 1'b1;
      fill_cnt <= (state != FILL || chg) ? '0 : fill_cnt + 1'b1;
      in_frame <= in_frame_nx;
      pending  <= pending_nx;
      a2f      <= a2f_nx;
      if (frm_inc && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      if (err_inc && err_cnt != '1)   err_cnt   <= err_cnt + 1'b1;
      xgmii_rxd <= lane_d;
      xgmii_rxc <= lane_c;
    end
  end
endmodule

// File: tb/tb_xgmii_lb_channel.sv
// Bench for xgmii_lb_channel: latency table, directed abort/inject/delay/reset
// sequences, and a randomized frame stream against a delay-line model.

module tb_xgmii_lb_channel;
  localparam int LANES     = 8;
  localparam int MAX_DELAY = 16;
  localparam int CNT_W     = 32;
  localparam logic [63:0] IDLE_D = {8{8'h07}};
  localparam logic [63:0] ERR_D  = {8{8'hFE}};

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } word_t;

  typedef struct {
    int dly;
    int lat;
  } lat_vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      txd;
  logic [7:0]       txc;
  logic             cfg_mode;
  logic [4:0]       cfg_delay;
  logic             err_inject;
  logic [63:0]      rxd;
  logic [7:0]       rxc;
  logic [CNT_W-1:0] frame_cnt, err_cnt;
  logic             busy;
  word_t            rx;

  assign rx = {rxd, rxc};
  always #5 clk = ~clk;

  xgmii_lb_channel #(.LANES(LANES), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .xgmii_txd      (txd),
    .xgmii_txc      (txc),
    .cfg_mode       (cfg_mode),
    .cfg_delay      (cfg_delay),
    .err_inject     (err_inject),
    .xgmii_rxd      (rxd),
    .xgmii_rxc      (rxc),
    .frame_cnt      (frame_cnt),
    .err_cnt        (err_cnt),
    .busy           (busy)
  );

  word_t txq[$];
  word_t fr[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic word_t idle_w();
    return {IDLE_D, 8'hFF};
  endfunction

  function automatic bit is_start(input word_t w);
    return w.c[0] && (w.d[7:0] == 8'hFB);
  endfunction

  function automatic bit has_term(input word_t w);
    for (int i = 0; i < 8; i++)
      if (w.c[i] && w.d[8*i +: 8] == 8'hFD) return 1'b1;
    return 1'b0;
  endfunction

  // Start, n random data words, Terminate in a random lane.
  task automatic push_frame(input int n);
    word_t w;
    int    k;
    fr.delete();
    w.d = {56'hD5555555555555, 8'hFB};
    w.c = 8'h01;
    fr.push_back(w);
    for (int i = 0; i < n; i++) begin
      w.d = {$urandom, $urandom};
      w.c = 8'h00;
      fr.push_back(w);
    end
    k = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++) begin
      if (i < k)       begin w.d[8*i +: 8] = 8'($urandom); w.c[i] = 1'b0; end
      else if (i == k) begin w.d[8*i +: 8] = 8'hFD;        w.c[i] = 1'b1; end
      else             begin w.d[8*i +: 8] = 8'h07;        w.c[i] = 1'b1; end
    end
    fr.push_back(w);
    foreach (fr[i]) txq.push_back(fr[i]);
  endtask

  task automatic step();
    word_t w;
    if (txq.size() > 0) w = txq.pop_front();
    else                w = idle_w();
    txd = w.d;
    txc = w.c;
    @(posedge clk);
    #1;
    err_inject = 1'b0;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!(rxd[7:0] == 8'hFB && rxc[0]) && k < 40);
  endtask

  task automatic do_reset(input int dly);
    rst_n      = 1'b0;
    cfg_delay  = 5'(dly);
    cfg_mode   = 1'b0;
    err_inject = 1'b0;
    txq.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    lat_vec_t tv[6];
    int       k, d, nfrm, nerr;
    bit       ok, locked, inframe, pending, inj, used;
    word_t    mq[$];
    word_t    cur, w, exp;

    tv = '{'{0, 1}, '{1, 2}, '{3, 4}, '{16, 17}, '{20, 17}, '{31, 17}};

    rst_n = 1'b0; txd = IDLE_D; txc = 8'hFF;
    cfg_mode = 1'b0; cfg_delay = 5'd3; err_inject = 1'b0;
    repeat (2) step();
    chk("reset_rx", rx, idle_w());
    chk("reset_busy", busy, 1);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_err_cnt", err_cnt, 0);

    // Latency = clamp(cfg_delay) + 1
    for (int i = 0; i < 6; i++) begin
      do_reset(tv[i].dly);
      push_frame(8);
      wait_start(k);
      chk($sformatf("latency_d%0d", tv[i].dly), k, tv[i].lat);
      chk("lat_frame_cnt", frame_cnt, 1);
      chk("lat_busy", busy, 0);
      repeat (20) step();
    end

    // Mode abort mid-frame, then resume only at the next Start
    do_reset(3);
    push_frame(8);
    wait_start(k);
    step();
    chk("abort_d1", rx, fr[1]);
    cfg_mode = 1'b1;
    step();
    chk("abort_last_word", rx, fr[2]);
    step();
    chk("abort_word", rx, {ERR_D, 8'hFF});
    step();
    chk("abort_then_idle", rx, idle_w());
    chk("abort_err_cnt", err_cnt, 1);
    cfg_mode = 1'b0;
    ok = 1'b1;
    repeat (12) begin
      step();
      if (rx !== idle_w()) ok = 1'b0;
    end
    chk("block_no_resume", ok, 1);
    push_frame(4);
    wait_start(k);
    chk("rehunt_latency", k, 4);
    chk("rehunt_frame_cnt", frame_cnt, 2);
    repeat (12) step();

    // Error injection, second pulse while pending ignored
    do_reset(2);
    push_frame(3);
    repeat (20) step();
    chk("inj_pass_busy", busy, 0);
    err_inject = 1'b1;
    step();
    step();
    err_inject = 1'b1;
    step();
    push_frame(4);
    wait_start(k);
    step();
    exp = fr[1];
    exp.d[7:0] = 8'hFE;
    exp.c[0]   = 1'b1;
    chk("inj_word", rx, exp);
    step();
    chk("inj_next_clean", rx, fr[2]);
    repeat (10) step();
    chk("inj_err_cnt", err_cnt, 1);
    chk("inj_frame_cnt", frame_cnt, 2);

    // Delay change mid-frame: abort, refill, re-hunt at the new latency
    do_reset(2);
    push_frame(8);
    wait_start(k);
    chk("chg_old_latency", k, 3);
    step();
    chk("chg_d1", rx, fr[1]);
    cfg_delay = 5'd5;
    step();
    chk("chg_last_word", rx, fr[2]);
    step();
    chk("chg_abort_word", rx, {ERR_D, 8'hFF});
    ok = 1'b1;
    repeat (6) begin
      step();
      if (rx !== idle_w()) ok = 1'b0;
    end
    chk("chg_fill_idle", ok, 1);
    chk("chg_err_cnt", err_cnt, 1);
    repeat (20) step();
    push_frame(4);
    wait_start(k);
    chk("chg_new_latency", k, 6);
    repeat (12) step();

    // Asynchronous reset mid-frame
    do_reset(1);
    push_frame(8);
    wait_start(k);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rx", rx, idle_w());
    chk("async_rst_frame_cnt", frame_cnt, 0);
    chk("async_rst_busy", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (25) begin
      step();
      if (rx !== idle_w()) ok = 1'b0;
    end
    chk("async_rst_no_err_word", ok, 1);
    chk("async_rst_err_cnt", err_cnt, 0);

    // Random frames and inject pulses against a delay-line model
    d = $urandom_range(0, 16);
    do_reset(d);
    mq.delete();
    for (int i = 0; i < d; i++) mq.push_back(idle_w());
    locked = 0; inframe = 0; pending = 0; nfrm = 0; nerr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (txq.size() == 0) begin
        repeat ($urandom_range(0, 3)) txq.push_back(idle_w());
        push_frame($urandom_range(1, 8));
      end
      cur = txq[0];
      mq.push_back(cur);
      w    = mq.pop_front();
      inj  = ($urandom_range(0, 7) == 0);
      used = 1'b0;
      exp  = idle_w();
      if (!locked && is_start(w)) begin
        locked  = 1'b1;
        inframe = 1'b0;
      end
      if (locked) begin
        exp = w;
        if (pending && inframe && !w.c[0]) begin
          exp.d[7:0] = 8'hFE;
          exp.c[0]   = 1'b1;
          used       = 1'b1;
          nerr++;
        end
        if (has_term(w))      inframe = 1'b0;
        else if (is_start(w)) inframe = 1'b1;
      end
      if (is_start(exp)) nfrm++;
      if (used)     pending = 1'b0;
      else if (inj) pending = 1'b1;
      err_inject = inj;
      step();
      chk($sformatf("rand_rx_c%0d", cyc), rx, exp);
    end
    chk("rand_frame_cnt", frame_cnt, nfrm);
    chk("rand_err_cnt", err_cnt, nerr);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
